attribute_predictor_mc: RTL and testbench
=========================================

# attribute_predictor_mc

Multi-channel, multi-mode attribute predictor for the LiDAR decoder attribute decompressor. Per point it takes K neighbouring attribute vectors (CHANNELS channels each) and a prediction mode, and forms a prediction by one of three methods: direct neighbour select, uniform average, or weight-normalised average (the division runs on a multi-cycle sequential divider). It then adds the decoded signed residual with saturation. It sits between the neighbour search and the attribute output buffer, with valid/ready handshakes on both sides.

## Interface
- ATTR_WIDTH, 8, bits per attribute channel
- K, 4, neighbours per point (≥1)
- CHANNELS, 3, attribute channels per point
- MODE_WIDTH, 3, mode field width (must hold K+1)
- WEIGHT_WIDTH, 8, unsigned per-neighbour weight width
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input point valid
- in_ready  out  1  block can accept; high only in IDLE, low while rst_n low
- prediction_mode  in  MODE_WIDTH  0..K-1 select, K average, K+1 weighted
- neighbor_attrs  in  K×CHANNELS×ATTR_WIDTH  unsigned neighbour attributes
- neighbor_weights  in  K×WEIGHT_WIDTH  unsigned weights (mode K+1 only)
- residual  in  CHANNELS×(ATTR_WIDTH+1)  signed two's-complement residuals
- out_valid  out  1  result valid, held until out_ready
- out_ready  in  1  downstream accepts
- predicted_attr  out  CHANNELS×ATTR_WIDTH  prediction
- reconstructed_attr  out  CHANNELS×ATTR_WIDTH  saturated prediction+residual
- mode_error  out  1  mode > K+1 for current result
- weight_fallback  out  1  weighted mode hit zero weight sum; average used

## Operation
- Accept when in_valid && in_ready; capture all inputs into registers.
- FSM: IDLE → (mode<K or mode>K+1) DONE; (mode K or K+1) ACCUM → DIVIDE → DONE; DONE → IDLE on out_ready.
- Select mode: pred[c] = neighbor_attrs[mode][c].
- Average mode: numerator Σ a[i][c]; denominator K.
- Weighted mode: numerator Σ w[i]·a[i][c]; denominator Σ w[i].
- If Σ w[i] == 0, use the average-mode numerator and denominator, and set weight_fallback.
- Invalid mode: pred = 0 for all channels, mode_error = 1, reconstruction still applied to residual.
- SUM_W = ATTR_WIDTH + WEIGHT_WIDTH + clog2(K).
- ACCUM registers the numerators (SUM_W bits) and the denominator.
- DIVIDE: restoring division, one quotient bit per cycle, all channels in parallel, SUM_W iterations, floor result.
- The quotient cannot exceed the maximum neighbour value. Output its low ATTR_WIDTH bits.
- Reconstruction: recon = clamp(pred + residual, 0, 2^ATTR_WIDTH−1), computed at ATTR_WIDTH+2 bits.
- Outputs, mode_error and weight_fallback stay stable while out_valid && !out_ready.

## Timing
- Reset (asynchronous): state IDLE.
- All outputs read 0 in reset, including out_valid, mode_error, weight_fallback, predicted_attr and reconstructed_attr. in_ready is 0 while rst_n is low and 1 from the first clock edge after release.
- Select/invalid mode: accept at edge N, out_valid high after edge N+1.
- Average/weighted mode: ACCUM at N+1, DIVIDE N+2..N+SUM_W+1, out_valid after edge N+SUM_W+2. With defaults this is 20 cycles.
- Throughput: one point in flight; in_ready goes high the cycle after the out_valid && out_ready handshake.
- Reset mid-ACCUM/DIVIDE/DONE: discard the point, clear out_valid immediately, return to IDLE.
- in_valid while busy: ignored, and it must be held by upstream.

## Structure
- Package attr_pred_pkg holds:
  - state enum (IDLE, ACCUM, DIVIDE, DONE);
  - localparam helpers for SUM_W and the MODE_AVG/MODE_WEIGHTED offsets relative to K;
  - saturating-add function.
- Sub-module attr_seq_divider: a parametrised SUM_W-bit restoring divider with start/busy/done, one instance per channel sharing the denominator.

## Test plan
- Mode 2, ch0 neighbours {10,20,30,40}, residual +5 → pred 30, recon 35, out_valid 1 cycle after accept, mode_error 0.
- Mode 4 (average), ch0 {10,20,30,41}, residual 0 → pred 25 (101/4 floor), out_valid exactly 20 cycles after accept.
- Mode 5 (weighted), weights {1,0,0,3}, ch0 {100,x,x,200} → pred 175.
- Mode 5 with weights all zero, ch0 {10,20,30,40} → pred 25, weight_fallback 1.
- Saturation and invalid mode:
  - mode 0, pred 250, residual +20 → recon 255;
  - pred 3, residual −10 → recon 0;
  - mode 7 → pred 0, mode_error 1.
- Backpressure and reset:
  - out_ready low 5 cycles → outputs stable, in_ready 0, new in_valid ignored;
  - rst_n pulsed mid-DIVIDE → out_valid 0 immediately, in_ready 1 on the first edge after release, next point processed correctly.

Source files
------------

// File: rtl/attribute_predictor_mc_pkg.sv
// Shared types and helpers for the multi-channel attribute predictor.
package attr_pred_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;

  // Averaging modes sit directly above the K neighbour-select modes.
  localparam int MODE_AVG_OFFSET      = 0;
  localparam int MODE_WEIGHTED_OFFSET = 1;

  function automatic int sum_width(int attr_w, int weight_w, int k);
    return attr_w + weight_w + $clog2(k);
  endfunction

  function automatic int sat_add(int pred, int res, int max_val);
    int s;
    s = pred + res;
    if (s < 0) return 0;
    if (s > max_val) return max_val;
    return s;
  endfunction

endpackage

// File: rtl/attribute_predictor_mc_if.sv
// Point-in / result-out handshake bundle of the attribute predictor.
interface attr_pred_if #(
  parameter int ATTR_WIDTH   = 8,
  parameter int K            = 4,
  parameter int CHANNELS     = 3,
  parameter int MODE_WIDTH   = 3,
  parameter int WEIGHT_WIDTH = 8
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic [MODE_WIDTH-1:0]                prediction_mode;
  logic [K*CHANNELS*ATTR_WIDTH-1:0]     neighbor_attrs;
  logic [K*WEIGHT_WIDTH-1:0]            neighbor_weights;
  logic [CHANNELS*(ATTR_WIDTH+1)-1:0]   residual;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [CHANNELS*ATTR_WIDTH-1:0]       predicted_attr;
  logic [CHANNELS*ATTR_WIDTH-1:0]       reconstructed_attr;
  logic                                 mode_error;
  logic                                 weight_fallback;

  modport master (
    output in_valid, prediction_mode, neighbor_attrs, neighbor_weights, residual, out_ready,
    input  in_ready, out_valid, predicted_attr, reconstructed_attr, mode_error, weight_fallback
  );

  modport slave (
    input  in_valid, prediction_mode, neighbor_attrs, neighbor_weights, residual, out_ready,
    output in_ready, out_valid, predicted_attr, reconstructed_attr, mode_error, weight_fallback
  );
endinterface

// File: rtl/attribute_predictor_mc_divider.sv
// Restoring divider, one quotient bit per cycle; the start edge already performs the first step.
module attr_seq_divider #(
  parameter int W     = 18,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     numer,
  input  logic [W-1:0]     denom,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] quotient
);
  localparam int CNT_W = $clog2(W);

  logic [W-1:0]     rem_q, quo_q, rem_in, quo_in;
  logic [W:0]       trial;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    rem_in = start ? '0 : rem_q;
    quo_in = start ? numer : quo_q;
    trial  = {rem_in, quo_in[W-1]} - {1'b0, denom};
  end

  always_ff @(posedge clk) begin
    if (start || busy) begin
      if (!trial[W]) begin
        rem_q <= trial[W-1:0];
        quo_q <= {quo_in[W-2:0], 1'b1};
      end else begin
        rem_q <= {rem_in[W-2:0], quo_in[W-1]};
        quo_q <= {quo_in[W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        cnt  <= CNT_W'(1);
      end else if (busy) begin
        if (cnt == CNT_W'(W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q[OUT_W-1:0];

endmodule

// File: rtl/attribute_predictor_mc.sv
// Per-point attribute prediction (select / average / weighted) plus saturated residual reconstruction.
module attribute_predictor_mc
  import attr_pred_pkg::*;
#(
  parameter int ATTR_WIDTH   = 8,
  parameter int K            = 4,
  parameter int CHANNELS     = 3,
  parameter int MODE_WIDTH   = 3,
  parameter int WEIGHT_WIDTH = 8
) (
  input logic       clk,
  input logic       rst_n,
  attr_pred_if.slave bus
);
  localparam int SUM_W    = sum_width(ATTR_WIDTH, WEIGHT_WIDTH, K);
  localparam int MAX_ATTR = (1 << ATTR_WIDTH) - 1;
  localparam logic [MODE_WIDTH-1:0] MODE_AVG = MODE_WIDTH'(K + MODE_AVG_OFFSET);
  localparam logic [MODE_WIDTH-1:0] MODE_WGT = MODE_WIDTH'(K + MODE_WEIGHTED_OFFSET);

  state_t state;
  logic   in_ready_r, out_valid_r, mode_error_r, weight_fallback_r, start_p1;
  logic [CHANNELS*ATTR_WIDTH-1:0] pred_r, recon_r, pred_c, recon_c;

  logic [MODE_WIDTH-1:0]              mode_p0;
  logic [K*CHANNELS*ATTR_WIDTH-1:0]   attrs_p0;
  logic [K*WEIGHT_WIDTH-1:0]          weights_p0;
  logic [CHANNELS*(ATTR_WIDTH+1)-1:0] residual_p0;

  logic [SUM_W-1:0] sum_w, den_c, den_p1;
  logic [SUM_W-1:0] sum_a [CHANNELS];
  logic [SUM_W-1:0] sum_wa [CHANNELS];
  logic [SUM_W-1:0] num_c [CHANNELS];
  logic [SUM_W-1:0] num_p1 [CHANNELS];
  logic             fallback_c, fallback_p1, use_wgt;

  logic [CHANNELS-1:0]   div_busy, div_done;
  logic [ATTR_WIDTH-1:0] quo [CHANNELS];
  logic [ATTR_WIDTH-1:0] pred_ch [CHANNELS];
  logic                  accept, div_fin, load;

  assign accept  = (state == IDLE) && in_ready_r && bus.in_valid;
  assign div_fin = (&div_done) & ~(|div_busy);
  assign load    = ((state == DIVIDE) && div_fin) || ((state == DONE) && !out_valid_r);

  // Stage p0 -> p1: numerator / denominator formation
  always_comb begin
    sum_w = '0;
    for (int i = 0; i < K; i++)
      sum_w = sum_w + SUM_W'(weights_p0[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
    fallback_c = (sum_w == '0);
    use_wgt    = (mode_p0 == MODE_WGT) && !fallback_c;
    den_c      = use_wgt ? sum_w : SUM_W'(K);
    for (int c = 0; c < CHANNELS; c++) begin
      sum_a[c]  = '0;
      sum_wa[c] = '0;
      for (int i = 0; i < K; i++) begin
        sum_a[c]  = sum_a[c] + SUM_W'(attrs_p0[(i*CHANNELS+c)*ATTR_WIDTH +: ATTR_WIDTH]);
        sum_wa[c] = sum_wa[c] + SUM_W'(weights_p0[i*WEIGHT_WIDTH +: WEIGHT_WIDTH])
                              * SUM_W'(attrs_p0[(i*CHANNELS+c)*ATTR_WIDTH +: ATTR_WIDTH]);
      end
      num_c[c] = use_wgt ? sum_wa[c] : sum_a[c];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mode_p0     <= bus.prediction_mode;
      attrs_p0    <= bus.neighbor_attrs;
      weights_p0  <= bus.neighbor_weights;
      residual_p0 <= bus.residual;
    end
    if (state == ACCUM) begin
      for (int c = 0; c < CHANNELS; c++) num_p1[c] <= num_c[c];
      den_p1      <= den_c;
      fallback_p1 <= fallback_c;
    end
  end

  // Stage p1 -> p2: divide, all channels sharing one denominator
  for (genvar c = 0; c < CHANNELS; c++) begin : g_div
    attr_seq_divider #(.W(SUM_W), .OUT_W(ATTR_WIDTH)) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_p1),
      .numer    (num_p1[c]),
      .denom    (den_p1),
      .busy     (div_busy[c]),
      .done     (div_done[c]),
      .quotient (quo[c])
    );
  end

  // Stage p2: prediction select and saturated reconstruction
  always_comb begin
    pred_c  = '0;
    recon_c = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pred_ch[c] = '0;
      if (mode_p0 < MODE_WIDTH'(K)) begin
        for (int i = 0; i < K; i++)
          if (mode_p0 == MODE_WIDTH'(i))
            pred_ch[c] = attrs_p0[(i*CHANNELS+c)*ATTR_WIDTH +: ATTR_WIDTH];
      end else if (mode_p0 <= MODE_WGT) begin
        pred_ch[c] = quo[c];
      end
      pred_c[c*ATTR_WIDTH +: ATTR_WIDTH]  = pred_ch[c];
      recon_c[c*ATTR_WIDTH +: ATTR_WIDTH] = ATTR_WIDTH'(sat_add(int'(pred_ch[c]),
          int'($signed(residual_p0[c*(ATTR_WIDTH+1) +: ATTR_WIDTH+1])), MAX_ATTR));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      in_ready_r        <= 1'b0;
      out_valid_r       <= 1'b0;
      mode_error_r      <= 1'b0;
      weight_fallback_r <= 1'b0;
      pred_r            <= '0;
      recon_r           <= '0;
      start_p1          <= 1'b0;
    end else begin
      start_p1 <= 1'b0;
      case (state)
        IDLE: begin
          in_ready_r <= 1'b1;
          if (accept) begin
            in_ready_r <= 1'b0;
            state <= (bus.prediction_mode == MODE_AVG || bus.prediction_mode == MODE_WGT)
                     ? ACCUM : DONE;
          end
        end
        ACCUM: begin
          start_p1 <= 1'b1;
          state    <= DIVIDE;
        end
        DIVIDE: if (div_fin) state <= DONE;
        DONE: begin
          if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (load) begin
        out_valid_r       <= 1'b1;
        pred_r            <= pred_c;
        recon_r           <= recon_c;
        mode_error_r      <= (mode_p0 > MODE_WGT);
        weight_fallback_r <= (mode_p0 == MODE_WGT) && fallback_p1;
      end
    end
  end

  assign bus.in_ready           = in_ready_r;
  assign bus.out_valid          = out_valid_r;
  assign bus.predicted_attr     = pred_r;
  assign bus.reconstructed_attr = recon_r;
  assign bus.mode_error         = mode_error_r;
  assign bus.weight_fallback    = weight_fallback_r;

endmodule

// File: tb/tb_attribute_predictor_mc.sv
// Bench for attribute_predictor_mc: directed scenarios plus random points against a plain-arithmetic model.
module tb_attribute_predictor_mc;
  localparam int AW = 8, K = 4, C = 3, MW = 3, WW = 8;
  localparam int DIV_LAT = 2 + AW + WW + $clog2(K);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  attr_pred_if #(.ATTR_WIDTH(AW), .K(K), .CHANNELS(C), .MODE_WIDTH(MW), .WEIGHT_WIDTH(WW)) bus();

  attribute_predictor_mc #(.ATTR_WIDTH(AW), .K(K), .CHANNELS(C), .MODE_WIDTH(MW), .WEIGHT_WIDTH(WW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int a [K][C];
  int w [K];
  int r [C];
  int mode;
  int exp_pred [C], exp_recon [C], exp_lat;
  logic exp_merr, exp_wfb;
  int obs_pred [C], obs_recon [C], obs_lat;
  logic obs_merr, obs_wfb;

  function automatic int clamp_attr(int v);
    if (v < 0) return 0;
    if (v > (1 << AW) - 1) return (1 << AW) - 1;
    return v;
  endfunction

  task automatic model();
    int sw, s, sws, p;
    sw = 0;
    for (int i = 0; i < K; i++) sw += w[i];
    exp_merr = (mode > K + 1);
    exp_wfb  = (mode == K + 1) && (sw == 0);
    exp_lat  = (mode == K || mode == K + 1) ? DIV_LAT : 1;
    for (int c = 0; c < C; c++) begin
      s = 0; sws = 0;
      for (int i = 0; i < K; i++) begin
        s   += a[i][c];
        sws += w[i] * a[i][c];
      end
      if (mode < K)          p = a[mode][c];
      else if (mode == K)    p = s / K;
      else if (mode == K+1)  p = (sw == 0) ? s / K : sws / sw;
      else                   p = 0;
      exp_pred[c]  = p;
      exp_recon[c] = clamp_attr(p + r[c]);
    end
  endtask

  task automatic random_point();
    for (int i = 0; i < K; i++) begin
      for (int c = 0; c < C; c++) a[i][c] = int'($urandom_range(0, 255));
      w[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
    end
    for (int c = 0; c < C; c++) r[c] = int'($urandom_range(0, 511)) - 256;
    mode = int'($urandom_range(0, 7));
  endtask

  task automatic drive_point();
    for (int i = 0; i < K; i++) begin
      for (int c = 0; c < C; c++) bus.neighbor_attrs[(i*C+c)*AW +: AW] = AW'(a[i][c]);
      bus.neighbor_weights[i*WW +: WW] = WW'(w[i]);
    end
    for (int c = 0; c < C; c++) bus.residual[c*(AW+1) +: AW+1] = (AW+1)'(r[c]);
    bus.prediction_mode = MW'(mode);
  endtask

  task automatic sample_outputs();
    for (int c = 0; c < C; c++) begin
      obs_pred[c]  = int'(bus.predicted_attr[c*AW +: AW]);
      obs_recon[c] = int'(bus.reconstructed_attr[c*AW +: AW]);
    end
    obs_merr = bus.mode_error;
    obs_wfb  = bus.weight_fallback;
  endtask

  // Call at a falling edge; returns with outputs sampled once out_valid rises (or budget expires).
  task automatic run_point();
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin @(negedge clk); guard++; end
    drive_point();
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    obs_lat = 0;
    while (!bus.out_valid && obs_lat < 100) begin @(negedge clk); obs_lat++; end
    sample_outputs();
  endtask

  task automatic finish_point();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    sample_outputs();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || obs_merr !== 1'b0 || obs_wfb !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got in_ready=%b out_valid=%b merr=%b wfb=%b want all 0",
               bus.in_ready, bus.out_valid, obs_merr, obs_wfb);
    end
    checks++;
    if (bus.predicted_attr !== '0 || bus.reconstructed_attr !== '0) begin
      errors++;
      $display("FAIL reset_data got pred=%h recon=%h want 0", bus.predicted_attr, bus.reconstructed_attr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready got %b want 0", bus.in_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_edge_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_select();
    random_point();
    a[0][0] = 10; a[1][0] = 20; a[2][0] = 30; a[3][0] = 40;
    r[0] = 5; mode = 2;
    model();
    run_point();
    checks++;
    if (obs_pred[0] !== 30 || obs_recon[0] !== 35) begin
      errors++;
      $display("FAIL select_ch0 got pred=%0d recon=%0d want 30 35", obs_pred[0], obs_recon[0]);
    end
    checks++;
    if (obs_lat !== 1 || obs_merr !== 1'b0) begin
      errors++;
      $display("FAIL select_lat got lat=%0d merr=%b want 1 0", obs_lat, obs_merr);
    end
    for (int c = 1; c < C; c++) begin
      checks++;
      if (obs_pred[c] !== exp_pred[c] || obs_recon[c] !== exp_recon[c]) begin
        errors++;
        $display("FAIL select_ch%0d got %0d/%0d want %0d/%0d", c, obs_pred[c], obs_recon[c],
                 exp_pred[c], exp_recon[c]);
      end
    end
    finish_point();
  endtask

  task automatic test_average();
    random_point();
    a[0][0] = 10; a[1][0] = 20; a[2][0] = 30; a[3][0] = 41;
    r[0] = 0; mode = K;
    model();
    run_point();
    checks++;
    if (obs_pred[0] !== 25 || obs_recon[0] !== 25) begin
      errors++;
      $display("FAIL average_ch0 got pred=%0d recon=%0d want 25 25", obs_pred[0], obs_recon[0]);
    end
    checks++;
    if (obs_lat !== 20) begin
      errors++;
      $display("FAIL average_lat got %0d want 20", obs_lat);
    end
    for (int c = 1; c < C; c++) begin
      checks++;
      if (obs_pred[c] !== exp_pred[c] || obs_recon[c] !== exp_recon[c]) begin
        errors++;
        $display("FAIL average_ch%0d got %0d/%0d want %0d/%0d", c, obs_pred[c], obs_recon[c],
                 exp_pred[c], exp_recon[c]);
      end
    end
    finish_point();
  endtask

  task automatic test_weighted();
    random_point();
    w[0] = 1; w[1] = 0; w[2] = 0; w[3] = 3;
    a[0][0] = 100; a[3][0] = 200; r[0] = 0; mode = K + 1;
    model();
    run_point();
    checks++;
    if (obs_pred[0] !== 175 || obs_wfb !== 1'b0 || obs_lat !== exp_lat) begin
      errors++;
      $display("FAIL weighted_ch0 got pred=%0d wfb=%b lat=%0d want 175 0 %0d", obs_pred[0], obs_wfb,
               obs_lat, exp_lat);
    end
    for (int c = 1; c < C; c++) begin
      checks++;
      if (obs_pred[c] !== exp_pred[c] || obs_recon[c] !== exp_recon[c]) begin
        errors++;
        $display("FAIL weighted_ch%0d got %0d/%0d want %0d/%0d", c, obs_pred[c], obs_recon[c],
                 exp_pred[c], exp_recon[c]);
      end
    end
    finish_point();
  endtask

  task automatic test_fallback();
    random_point();
    for (int i = 0; i < K; i++) w[i] = 0;
    a[0][0] = 10; a[1][0] = 20; a[2][0] = 30; a[3][0] = 40;
    mode = K + 1;
    model();
    run_point();
    checks++;
    if (obs_pred[0] !== 25 || obs_wfb !== 1'b1 || obs_merr !== 1'b0) begin
      errors++;
      $display("FAIL fallback got pred=%0d wfb=%b merr=%b want 25 1 0", obs_pred[0], obs_wfb, obs_merr);
    end
    checks++;
    if (obs_recon[0] !== exp_recon[0] || obs_pred[2] !== exp_pred[2]) begin
      errors++;
      $display("FAIL fallback_other got recon0=%0d pred2=%0d want %0d %0d", obs_recon[0], obs_pred[2],
               exp_recon[0], exp_pred[2]);
    end
    finish_point();
  endtask

  task automatic test_saturation();
    random_point();
    mode = 0;
    a[0][0] = 250; r[0] = 20;
    a[0][1] = 3;   r[1] = -10;
    a[0][2] = 0;   r[2] = -256;
    model();
    run_point();
    checks++;
    if (obs_recon[0] !== 255 || obs_pred[0] !== 250) begin
      errors++;
      $display("FAIL sat_high got pred=%0d recon=%0d want 250 255", obs_pred[0], obs_recon[0]);
    end
    checks++;
    if (obs_recon[1] !== 0 || obs_recon[2] !== 0) begin
      errors++;
      $display("FAIL sat_low got recon1=%0d recon2=%0d want 0 0", obs_recon[1], obs_recon[2]);
    end
    finish_point();
  endtask

  task automatic test_invalid();
    random_point();
    mode = 7; r[0] = 7; r[1] = -3; r[2] = 255;
    model();
    run_point();
    checks++;
    if (obs_merr !== 1'b1 || obs_lat !== 1) begin
      errors++;
      $display("FAIL invalid_flag got merr=%b lat=%0d want 1 1", obs_merr, obs_lat);
    end
    for (int c = 0; c < C; c++) begin
      checks++;
      if (obs_pred[c] !== 0 || obs_recon[c] !== exp_recon[c]) begin
        errors++;
        $display("FAIL invalid_ch%0d got %0d/%0d want 0/%0d", c, obs_pred[c], obs_recon[c], exp_recon[c]);
      end
    end
    finish_point();
  endtask

  task automatic test_backpressure();
    int idle_ok;
    random_point();
    mode = 1;
    model();
    run_point();
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.prediction_mode = MW'(3);
      @(negedge clk);
      sample_outputs();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || obs_pred[0] !== exp_pred[0] ||
          obs_recon[2] !== exp_recon[2] || obs_merr !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold cyc %0d got ov=%b rdy=%b pred0=%0d recon2=%0d want 1 0 %0d %0d",
                 k, bus.out_valid, bus.in_ready, obs_pred[0], obs_recon[2], exp_pred[0], exp_recon[2]);
      end
    end
    bus.in_valid = 1'b0;
    finish_point();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release got rdy=%b ov=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    idle_ok = 1;
    repeat (3) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) idle_ok = 0;
    end
    checks++;
    if (idle_ok != 1) begin
      errors++;
      $display("FAIL backpressure_ignored got spurious out_valid want none");
    end
  endtask

  task automatic test_reset_mid_flight();
    random_point();
    mode = K;
    drive_point();
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_divide got ov=%b rdy=%b want 0 0", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_divide_release got rdy=%b ov=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    random_point();
    mode = 1;
    model();
    run_point();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.predicted_attr !== '0 || bus.reconstructed_attr !== '0) begin
      errors++;
      $display("FAIL reset_done got ov=%b pred=%h recon=%h want 0 0 0", bus.out_valid,
               bus.predicted_attr, bus.reconstructed_attr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    random_point();
    mode = K + 1;
    model();
    run_point();
    checks++;
    if (obs_lat !== exp_lat || obs_pred[0] !== exp_pred[0] || obs_recon[1] !== exp_recon[1] ||
        obs_wfb !== exp_wfb) begin
      errors++;
      $display("FAIL reset_next_point got lat=%0d pred0=%0d recon1=%0d wfb=%b want %0d %0d %0d %b",
               obs_lat, obs_pred[0], obs_recon[1], obs_wfb, exp_lat, exp_pred[0], exp_recon[1], exp_wfb);
    end
    finish_point();
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      random_point();
      model();
      run_point();
      checks++;
      if (obs_lat !== exp_lat || obs_merr !== exp_merr || obs_wfb !== exp_wfb) begin
        errors++;
        $display("FAIL random%0d_ctrl mode %0d got lat=%0d merr=%b wfb=%b want %0d %b %b", n, mode,
                 obs_lat, obs_merr, obs_wfb, exp_lat, exp_merr, exp_wfb);
      end
      for (int c = 0; c < C; c++) begin
        checks++;
        if (obs_pred[c] !== exp_pred[c] || obs_recon[c] !== exp_recon[c]) begin
          errors++;
          $display("FAIL random%0d_ch%0d mode %0d got %0d/%0d want %0d/%0d", n, c, mode,
                   obs_pred[c], obs_recon[c], exp_pred[c], exp_recon[c]);
        end
      end
      finish_point();
    end
  endtask

  initial begin
    bus.in_valid         = 1'b0;
    bus.out_ready        = 1'b0;
    bus.prediction_mode  = '0;
    bus.neighbor_attrs   = '0;
    bus.neighbor_weights = '0;
    bus.residual         = '0;
    test_reset();
    test_select();
    test_average();
    test_weighted();
    test_fallback();
    test_saturation();
    test_invalid();
    test_backpressure();
    test_reset_mid_flight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
